// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer with lock timeout, stability filter and retry/fault handling
module pll_lock_sequencer #(
    parameter int RST_HOLD     = 24,
    parameter int LOCK_TIMEOUT = 24000,
    parameter int LOCK_STABLE  = 240,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    // One shared counter must cover the longest of the three timed phases.
    localparam int CNT_MAX_A = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    retry_n;
    logic [7:0]    loss_n;
    logic [1:0]    sync_q;
    logic          locked_s;

    // Two-flop synchronizer for the PLL lock flag, which is asynchronous to refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // Next-state, counter, retry and lock-loss bookkeeping; relock_req overrides every transition.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        retry_n = retry_cnt;
        loss_n  = lock_loss_cnt;
        if (relock_req) begin
            state_n = S_HOLD;
            retry_n = 4'd0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == CW'(RST_HOLD - 1)) begin
                        state_n = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock wins over a timeout on the same cycle.
                    if (locked_s) begin
                        state_n = S_STABLE;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        if (retry_cnt < 4'(MAX_RETRY)) begin
                            retry_n = retry_cnt + 4'd1;
                            state_n = S_HOLD;
                        end else begin
                            state_n = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    // A lock glitch here restarts the lock wait without counting as a failed attempt.
                    if (!locked_s) begin
                        state_n = S_WAIT_LOCK;
                    end else if (cnt == CW'(LOCK_STABLE - 1)) begin
                        state_n = S_RUN;
                        retry_n = 4'd0;
                    end
                end
                S_RUN: begin
                    // The counter is meaningless in RUN; freeze it rather than let it wrap.
                    cnt_n = cnt;
                    if (!locked_s) begin
                        state_n = S_HOLD;
                        if (lock_loss_cnt != 8'hFF) begin
                            loss_n = lock_loss_cnt + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    cnt_n = cnt;
                end
                default: begin
                    state_n = S_HOLD;
                end
            endcase
        end
        if (relock_req || (state_n != state)) begin
            cnt_n = '0;
        end
    end

    // State register plus outputs decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= S_HOLD;
            cnt           <= '0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            retry_cnt     <= retry_n;
            lock_loss_cnt <= loss_n;
            pll_rst       <= (state_n == S_HOLD) || (state_n == S_FAULT);
            sys_rst       <= (state_n != S_RUN);
            ready         <= (state_n == S_RUN);
            fault         <= (state_n == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    localparam int RH = 4;
    localparam int TO = 16;
    localparam int LS = 8;
    localparam int MR = 2;

    localparam int P_HOLD   = 10;
    localparam int P_WAIT   = 20;
    localparam int P_STABLE = 30;
    localparam int P_RUN    = 40;
    localparam int P_FAULT  = 50;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks;
    int n_fail;
    int edge_no;

    int   m_ph;
    int   m_remain;
    int   m_fails;
    int   m_loss;
    logic m_hist[$];

    pll_lock_sequencer #(
        .RST_HOLD(RH),
        .LOCK_TIMEOUT(TO),
        .LOCK_STABLE(LS),
        .MAX_RETRY(MR)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .fault(fault),
        .retry_cnt(retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph     = P_HOLD;
        m_remain = RH;
        m_fails  = 0;
        m_loss   = 0;
        m_hist   = {};
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endtask

    // Behavioural reference: phases with countdown timers; lock seen two edges late.
    task automatic model_edge();
        logic seen;
        seen = m_hist.pop_front();
        m_hist.push_back(pll_locked);
        if (relock_req) begin
            m_ph     = P_HOLD;
            m_remain = RH;
            m_fails  = 0;
        end else if (m_ph == P_HOLD) begin
            m_remain--;
            if (m_remain == 0) begin
                m_ph     = P_WAIT;
                m_remain = TO;
            end
        end else if (m_ph == P_WAIT) begin
            if (seen) begin
                m_ph     = P_STABLE;
                m_remain = LS;
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    if (m_fails < MR) begin
                        m_fails++;
                        m_ph     = P_HOLD;
                        m_remain = RH;
                    end else begin
                        m_ph = P_FAULT;
                    end
                end
            end
        end else if (m_ph == P_STABLE) begin
            if (!seen) begin
                m_ph     = P_WAIT;
                m_remain = TO;
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_ph    = P_RUN;
                    m_fails = 0;
                end
            end
        end else if (m_ph == P_RUN) begin
            if (!seen) begin
                m_ph     = P_HOLD;
                m_remain = RH;
                m_loss   = (m_loss >= 255) ? 255 : m_loss + 1;
            end
        end
    endtask

    task automatic check_all();
        chk("pll_rst", pll_rst, (m_ph == P_HOLD) || (m_ph == P_FAULT));
        chk("sys_rst", sys_rst, m_ph != P_RUN);
        chk("ready", ready, m_ph == P_RUN);
        chk("fault", fault, m_ph == P_FAULT);
        chk("retry_cnt", retry_cnt, m_fails);
        chk("lock_loss_cnt", lock_loss_cnt, m_loss);
        chk("ready_xor_sys_rst", ready ^ sys_rst, 1);
        chk("fault_and_ready", fault & ready, 0);
    endtask

    task automatic step(input logic lk, input logic rq);
        pll_locked = lk;
        relock_req = rq;
        @(posedge refclk);
        model_edge();
        edge_no++;
        @(negedge refclk);
        check_all();
        relock_req = 1'b0;
    endtask

    task automatic do_reset(input logic lk);
        @(negedge refclk);
        rst        = 1'b1;
        relock_req = 1'b0;
        pll_locked = lk;
        model_reset();
        #1;
        check_all();
        @(negedge refclk);
        @(negedge refclk);
        rst     = 1'b0;
        edge_no = 0;
        check_all();
    endtask

    initial begin
        int hold_obs;
        int ready_edge;
        int r1_edge;
        int r2_edge;
        int fault_edge;
        int n;
        int fault_obs;
        logic lk;
        int dur;

        n_checks   = 0;
        n_fail     = 0;
        edge_no    = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        model_reset();

        // 1: cold start with lock already present
        do_reset(1'b1);
        hold_obs   = int'(pll_rst);
        ready_edge = -1;
        for (int i = 0; i < 40 && ready_edge < 0; i++) begin
            step(1'b1, 1'b0);
            if (pll_rst) hold_obs++;
            if (ready) ready_edge = edge_no;
        end
        chk("cold_pll_rst_cycles", hold_obs, RH);
        chk("cold_ready_edge", ready_edge, RH + 1 + LS);
        chk("cold_sys_rst", sys_rst, 0);
        chk("cold_retry", retry_cnt, 0);

        // 2: lock glitch after 5 stable cycles; lock seen low from edge 8 to 10
        do_reset(1'b1);
        ready_edge = -1;
        for (int i = 0; i < 60 && ready_edge < 0; i++) begin
            lk = ((edge_no + 1 >= 8) && (edge_no + 1 <= 10)) ? 1'b0 : 1'b1;
            step(lk, 1'b0);
            if (ready) ready_edge = edge_no;
        end
        chk("glitch_ready_edge", ready_edge, 21);
        chk("glitch_retry", retry_cnt, 0);

        // 3: no lock at all, retries exhaust into fault
        do_reset(1'b0);
        r1_edge    = -1;
        r2_edge    = -1;
        fault_edge = -1;
        for (int i = 0; i < 100 && fault_edge < 0; i++) begin
            step(1'b0, 1'b0);
            if (retry_cnt == 4'd1 && r1_edge < 0) r1_edge = edge_no;
            if (retry_cnt == 4'd2 && r2_edge < 0) r2_edge = edge_no;
            if (fault) fault_edge = edge_no;
        end
        chk("timeout_retry1_edge", r1_edge, RH + TO);
        chk("timeout_retry2_edge", r2_edge, 2 * (RH + TO));
        chk("timeout_fault_edge", fault_edge, 3 * (RH + TO));
        chk("fault_pll_rst", pll_rst, 1);
        fault_obs = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0);
            if (fault) fault_obs++;
        end
        chk("fault_held_cycles", fault_obs, 100);
        step(1'b0, 1'b1);
        chk("relock_clears_fault", fault, 0);
        chk("relock_clears_retry", retry_cnt, 0);
        chk("relock_enters_hold", pll_rst, 1);

        // 4: repeated lock loss in RUN, counter saturates
        do_reset(1'b1);
        for (int i = 0; i < 40 && !ready; i++) step(1'b1, 1'b0);
        chk("loss_initial_ready", ready, 1);
        for (int k = 1; k <= 300; k++) begin
            n = 0;
            do begin
                step(1'b0, 1'b0);
                n++;
            end while (ready && n < 10);
            chk("loss_latency", n, 3);
            chk("loss_pll_rst", pll_rst, 1);
            chk("loss_count", lock_loss_cnt, (k > 255) ? 255 : k);
            n = 0;
            do begin
                step(1'b1, 1'b0);
                n++;
            end while (!ready && n < 50);
            chk("loss_relock_ready", ready, 1);
        end

        // 5: relock request in RUN, then again at hold count 2
        step(1'b1, 1'b1);
        chk("req_run_pll_rst", pll_rst, 1);
        chk("req_run_ready", ready, 0);
        chk("req_run_loss_kept", lock_loss_cnt, 255);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n = 0;
        while (pll_rst && n < 20) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("req_hold_restart_cycles", n, RH);

        // 6: asynchronous reset between edges while in STABLE
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("pre_async_ready", ready, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_pll_rst", pll_rst, 1);
        chk("async_sys_rst", sys_rst, 1);
        chk("async_ready", ready, 0);
        chk("async_loss_cleared", lock_loss_cnt, 0);
        check_all();
        @(negedge refclk);
        rst     = 1'b0;
        edge_no = 0;
        check_all();

        // Random lock waveform with sparse relock requests against the reference model
        for (int b = 0; b < 120; b++) begin
            lk  = 1'($urandom_range(0, 1));
            dur = $urandom_range(1, 60);
            for (int i = 0; i < dur; i++) begin
                step(lk, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the IF clock PLL. It runs on the free-running 24 MHz reference clock and holds the PLL in reset for a defined time after power-up. It then waits for lock with a timeout, requires lock to stay high continuously before releasing the downstream system reset, and re-sequences the PLL on lock loss or on software request. It sits between the board reset/control logic and the PLL wrapper, and drives the PLL `rst` input and the synchronous-release reset used by the 48 MHz, 61.44 MHz and 3 MHz clock domains.

## Interface
Parameters:
- `RST_HOLD`, 24: refclk cycles `pll_rst` is held high per attempt (1 µs at 24 MHz); must be ≥1.
- `LOCK_TIMEOUT`, 24000: refclk cycles allowed in WAIT_LOCK before the attempt counts as failed; must be ≥1.
- `LOCK_STABLE`, 240: consecutive refclk cycles of synchronized lock required before release; must be ≥1.
- `MAX_RETRY`, 3: failed attempts tolerated before FAULT; range 0..15.

Ports:
- `refclk` in 1: free-running reference clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL `locked` output; asynchronous to `refclk`.
- `relock_req` in 1: single-cycle request to re-sequence the PLL; also clears FAULT.
- `pll_rst` out 1: drives the PLL reset input.
- `sys_rst` out 1: active-high reset for downstream clock domains. Each domain synchronizes its deassertion locally.
- `ready` out 1: PLL locked and stable; `sys_rst` released.
- `fault` out 1: lock was not achieved within `MAX_RETRY`+1 attempts.
- `retry_cnt` out 4: failed attempts since the last successful lock or `relock_req`.
- `lock_loss_cnt` out 8: saturating count of lock losses while in RUN; cleared only by `rst`.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. Both flops reset to 0.
- A single cycle counter `cnt` is shared by all states and cleared on every state change.
- All outputs are registered and decoded from the next state, so they change on the same `refclk` edge on which the state register changes.
- **HOLD:** `pll_rst`=1, `sys_rst`=1. Go to WAIT_LOCK when `cnt`==`RST_HOLD`-1, so HOLD lasts exactly `RST_HOLD` cycles.
- **WAIT_LOCK:** `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=1 → STABLE.
  - Otherwise, when `cnt`==`LOCK_TIMEOUT`-1:
    - if `retry_cnt`<`MAX_RETRY`: increment `retry_cnt`, go to HOLD;
    - else go to FAULT.
  - If `locked_s` rises on the timeout cycle, lock wins.
- **STABLE:** `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=0 → WAIT_LOCK. The timeout restarts and `retry_cnt` is unchanged.
  - `cnt`==`LOCK_STABLE`-1 with `locked_s`=1 → RUN.
- **RUN:** `pll_rst`=0, `sys_rst`=0, `ready`=1. `retry_cnt` is cleared on entry.
  - `locked_s`=0 → HOLD, and `lock_loss_cnt` increments (saturates at 255).
- **FAULT:** `pll_rst`=1, `sys_rst`=1, `fault`=1. Stays in FAULT until `relock_req` or `rst`.
- **`relock_req`:** in any state, takes priority over every other transition.
  - Go to HOLD, clear `retry_cnt` and `cnt`, and clear `fault` on that edge.
  - `lock_loss_cnt` is not incremented.
  - In HOLD, it restarts the hold period.
- Reset values (asynchronous, applied immediately on `rst` in any state):
  - state=HOLD, `cnt`=0;
  - `pll_rst`=1, `sys_rst`=1;
  - `ready`=0, `fault`=0;
  - `retry_cnt`=0, `lock_loss_cnt`=0.
- `pll_rst` and `sys_rst` must be glitch-free: each comes directly from a flop.

## Timing
- Synchronizer latency: a change on `pll_locked` is visible in `locked_s` 2 edges later. State reaction follows on the next edge.
- Best-case cold start, with `pll_locked` already high: HOLD for `RST_HOLD` cycles, then WAIT_LOCK for 1 cycle, then STABLE for `LOCK_STABLE` cycles. `ready` rises at edge `RST_HOLD`+1+`LOCK_STABLE` after the first edge following `rst` release.
- Lock loss in RUN: `sys_rst` rises and `ready` falls 3 edges after `pll_locked` falls (2 sync + 1 state).
- `ready` and `sys_rst` are always complementary. `fault`=1 implies `ready`=0.

## Test plan
Bench parameters: `RST_HOLD`=4, `LOCK_TIMEOUT`=16, `LOCK_STABLE`=8, `MAX_RETRY`=2.
1. **Cold start:** `pll_locked` held at 1 throughout, release `rst` → `pll_rst`=1 for exactly 4 cycles; `ready`=1 and `sys_rst`=0 at edge 13; `retry_cnt`=0.
2. **Lock glitch during STABLE:** in STABLE, drop `pll_locked` for 3 cycles after 5 stable cycles → back to WAIT_LOCK; after lock returns, a full 8-cycle STABLE is required before RUN; `retry_cnt` stays 0.
3. **Timeout to fault:** `pll_locked`=0 throughout → 3 HOLD/WAIT_LOCK attempts, `retry_cnt` steps 1 then 2, then `fault`=1 with `pll_rst`=1. FAULT holds for 100 cycles. `relock_req` pulse → `fault`=0, `retry_cnt`=0, HOLD.
4. **Lock loss in RUN:** in RUN, drop `pll_locked` → `ready`=0 and `pll_rst`=1 3 edges later, `lock_loss_cnt`=1; relock proceeds normally. Repeat 300 times → `lock_loss_cnt` saturates at 255.
5. **`relock_req` in RUN and in mid-HOLD:** in RUN → HOLD, `lock_loss_cnt` unchanged. Pulsed at HOLD `cnt`=2 → hold period restarts, giving 4 further cycles.
6. **Async reset mid-STABLE:** assert `rst` between clock edges → all outputs at reset values immediately, with no clock edge required.
